// File: rtl/prog_loader_if.sv
// Host byte stream into the program loader: valid/ready handshake carrying one byte per transfer.
interface prog_loader_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/prog_loader.sv
// Instruction memory writer: unpacks a COUNT/(HI,LO)*N/CHK byte stream into 9-bit
// instructions, verifies the XOR checksum and gates the core reset accordingly.
module prog_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  prog_loader_if.slave       rx,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               core_reset,
  input  logic               core_done,
  output logic               busy,
  output logic               loaded,
  output logic               halted,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [ADDR_W:0]    instr_count
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCount = 3'd1;
  localparam logic [2:0] StHi    = 3'd2;
  localparam logic [2:0] StLo    = 3'd3;
  localparam logic [2:0] StCheck = 3'd4;
  localparam logic [2:0] StRun   = 3'd5;
  localparam logic [2:0] StHalt  = 3'd6;
  localparam logic [2:0] StErr   = 3'd7;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  index_q, index_d;
  logic [7:0]         csum_q, csum_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               bit8_q, bit8_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               im_we_q, im_we_d;
  logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
  logic [INSTR_W-1:0] im_wdata_q, im_wdata_d;
  logic               accept;
  logic               last_instr;

  // Pure state decodes: no combinational path from rx.valid into rx.ready.
  always_comb begin
    busy       = (state_q == StCount) || (state_q == StHi) ||
                 (state_q == StLo) || (state_q == StCheck);
    loaded     = (state_q == StRun) || (state_q == StHalt);
    halted     = (state_q == StHalt);
    error      = (state_q == StErr);
    core_reset = !loaded;
  end

  assign rx.ready    = busy;
  assign accept      = rx.valid && busy;
  assign last_instr  = ({1'b0, index_q} == (count_q - (ADDR_W+1)'(1)));
  assign im_we       = im_we_q;
  assign im_addr     = im_addr_q;
  assign im_wdata    = im_wdata_q;
  assign err_code    = err_code_q;
  assign instr_count = count_q;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    csum_d     = csum_q;
    timer_d    = timer_q;
    bit8_d     = bit8_q;
    err_code_d = err_code_q;
    count_d    = count_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    case (state_q)
      StIdle, StRun, StHalt, StErr: begin
        if (load_req) begin
          state_d    = StCount;
          err_code_d = 2'd0;
          timer_d    = '0;
        end else if ((state_q == StRun) && core_done) begin
          state_d = StHalt;
        end
      end
      StCount: begin
        if (accept) begin
          // A zero count byte encodes a full 256-entry image.
          count_d = (rx.data == 8'd0) ? (ADDR_W+1)'(256) : (ADDR_W+1)'(rx.data);
          index_d = '0;
          csum_d  = rx.data;
          state_d = StHi;
        end
      end
      StHi: begin
        if (accept) begin
          if (|rx.data[7:1]) begin
            state_d    = StErr;
            err_code_d = 2'd1;
          end else begin
            bit8_d  = rx.data[0];
            csum_d  = csum_q ^ rx.data;
            state_d = StLo;
          end
        end
      end
      StLo: begin
        if (accept) begin
          csum_d     = csum_q ^ rx.data;
          im_we_d    = 1'b1;
          im_addr_d  = index_q;
          im_wdata_d = INSTR_W'({bit8_q, rx.data});
          if (last_instr) begin
            state_d = StCheck;
          end else begin
            index_d = index_q + ADDR_W'(1);
            state_d = StHi;
          end
        end
      end
      StCheck: begin
        if (accept) begin
          if (rx.data == csum_q) begin
            state_d = StRun;
          end else begin
            state_d    = StErr;
            err_code_d = 2'd3;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Idle-gap watchdog; an accepted byte always restarts it.
    if (busy) begin
      if (accept) begin
        timer_d = '0;
      end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
        state_d    = StErr;
        err_code_d = 2'd2;
      end else begin
        timer_d = timer_q + TimerW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      index_q    <= '0;
      csum_q     <= '0;
      timer_q    <= '0;
      bit8_q     <= 1'b0;
      err_code_q <= 2'd0;
      count_q    <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      csum_q     <= csum_d;
      timer_q    <= timer_d;
      bit8_q     <= bit8_d;
      err_code_q <= err_code_d;
      count_q    <= count_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

endmodule
